// File: rtl/rs_pool.sv
`default_nettype none
// ============================================================================
// Module   : rs_pool
// Function : Unified reservation-station pool. Captures operands from NUM_CDB
//            broadcast channels and issues the oldest ready entry per FU class.
//            Define RS_WAKEUP_BYPASS_EN for zero-cycle wakeup with CDB value
//            forwarding onto the issue operands.
// Revision : 1.0
// ============================================================================
module rs_pool #(
    parameter int NUM_ENTRIES  = 8,
    parameter int NUM_FU_TYPES = 4,
    parameter int NUM_CDB      = 2,
    parameter int ROB_TAG_W    = 5,
    parameter int XLEN         = 32,
    parameter int PAYLOAD_W    = 64
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 squash,
    input  logic                                 dp_valid,
    output logic                                 dp_ready,
    input  logic [$clog2(NUM_FU_TYPES)-1:0]      dp_fu_type,
    input  logic [ROB_TAG_W-1:0]                 dp_rob_tag,
    input  logic [ROB_TAG_W-1:0]                 dp_t1,
    input  logic [ROB_TAG_W-1:0]                 dp_t2,
    input  logic                                 dp_r1,
    input  logic                                 dp_r2,
    input  logic [XLEN-1:0]                      dp_v1,
    input  logic [XLEN-1:0]                      dp_v2,
    input  logic [PAYLOAD_W-1:0]                 dp_payload,
    input  logic [NUM_CDB-1:0]                   cdb_valid,
    input  logic [NUM_CDB*ROB_TAG_W-1:0]         cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]              cdb_value,
    output logic [NUM_FU_TYPES-1:0]              issue_valid,
    input  logic [NUM_FU_TYPES-1:0]              issue_ready,
    output logic [NUM_FU_TYPES*ROB_TAG_W-1:0]    issue_rob_tag,
    output logic [NUM_FU_TYPES*XLEN-1:0]         issue_v1,
    output logic [NUM_FU_TYPES*XLEN-1:0]         issue_v2,
    output logic [NUM_FU_TYPES*PAYLOAD_W-1:0]    issue_payload,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]     free_count
);

    localparam int FT_W  = $clog2(NUM_FU_TYPES);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam logic [CNT_W-1:0] C_FULL   = CNT_W'(NUM_ENTRIES);
    localparam logic [FT_W:0]    C_NUM_FU = (FT_W + 1)'(NUM_FU_TYPES);

    typedef struct packed {
        logic            hit;
        logic [XLEN-1:0] val;
    } cdb_hit_t;

    // Lowest channel index wins when several channels carry the same tag.
    function automatic cdb_hit_t cdb_lookup(
        input logic [ROB_TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]           vld,
        input logic [NUM_CDB*ROB_TAG_W-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]      vals
    );
        cdb_hit_t res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (vld[k] && (tags[k*ROB_TAG_W +: ROB_TAG_W] == tag)) begin
                res.hit = 1'b1;
                res.val = vals[k*XLEN +: XLEN];
            end
        end
        return res;
    endfunction

    // Entry state
    logic [NUM_ENTRIES-1:0] busy_q;
    logic [NUM_ENTRIES-1:0] r1_q;
    logic [NUM_ENTRIES-1:0] r2_q;
    logic [FT_W-1:0]        fu_q   [NUM_ENTRIES];
    logic [ROB_TAG_W-1:0]   tag_q  [NUM_ENTRIES];
    logic [ROB_TAG_W-1:0]   t1_q   [NUM_ENTRIES];
    logic [ROB_TAG_W-1:0]   t2_q   [NUM_ENTRIES];
    logic [XLEN-1:0]        v1_q   [NUM_ENTRIES];
    logic [XLEN-1:0]        v2_q   [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]   pay_q  [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] age_q  [NUM_ENTRIES];
    logic [CNT_W-1:0]       free_count_q;

    // Combinational
    cdb_hit_t               lk1 [NUM_ENTRIES];
    cdb_hit_t               lk2 [NUM_ENTRIES];
    cdb_hit_t               dp_lk1;
    cdb_hit_t               dp_lk2;
    logic [NUM_ENTRIES-1:0] wk1;
    logic [NUM_ENTRIES-1:0] wk2;
    logic [NUM_ENTRIES-1:0] rdy;
    logic [XLEN-1:0]        op1 [NUM_ENTRIES];
    logic [XLEN-1:0]        op2 [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] cand [NUM_FU_TYPES];
    logic [NUM_ENTRIES-1:0] sel  [NUM_FU_TYPES];
    logic [NUM_FU_TYPES-1:0] fire;
    logic [NUM_ENTRIES-1:0] freed;
    logic [CNT_W-1:0]       n_fire;
    logic [IDX_W-1:0]       alloc_idx;
    logic                   fu_ok;
    logic                   alloc_ok;
    logic [NUM_ENTRIES-1:0] busy_d;
    logic [CNT_W-1:0]       free_count_d;

    assign dp_ready   = (free_count_q != '0);
    assign free_count = free_count_q;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            lk1[i] = cdb_lookup(t1_q[i], cdb_valid, cdb_tag, cdb_value);
            lk2[i] = cdb_lookup(t2_q[i], cdb_valid, cdb_tag, cdb_value);
        end
        dp_lk1 = cdb_lookup(dp_t1, cdb_valid, cdb_tag, cdb_value);
        dp_lk2 = cdb_lookup(dp_t2, cdb_valid, cdb_tag, cdb_value);
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            wk1[i] = busy_q[i] & ~r1_q[i] & lk1[i].hit;
            wk2[i] = busy_q[i] & ~r2_q[i] & lk2[i].hit;
`ifdef RS_WAKEUP_BYPASS_EN
            rdy[i] = busy_q[i] & (r1_q[i] | wk1[i]) & (r2_q[i] | wk2[i]);
            op1[i] = r1_q[i] ? v1_q[i] : lk1[i].val;
            op2[i] = r2_q[i] ? v2_q[i] : lk2[i].val;
`else
            rdy[i] = busy_q[i] & r1_q[i] & r2_q[i];
            op1[i] = v1_q[i];
            op2[i] = v2_q[i];
`endif
        end
    end

    always_comb begin
        for (int f = 0; f < NUM_FU_TYPES; f++) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cand[f][i] = rdy[i] && (fu_q[i] == FT_W'(f));
            end
        end
    end

    // An entry wins its port when it is older than every other candidate.
    always_comb begin
        for (int f = 0; f < NUM_FU_TYPES; f++) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                sel[f][i] = cand[f][i];
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if ((j != i) && cand[f][j] && !age_q[i][j]) begin
                        sel[f][i] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        issue_valid   = '0;
        issue_rob_tag = '0;
        issue_v1      = '0;
        issue_v2      = '0;
        issue_payload = '0;
        for (int f = 0; f < NUM_FU_TYPES; f++) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (sel[f][i]) begin
                    issue_valid[f]                              = 1'b1;
                    issue_rob_tag[f*ROB_TAG_W +: ROB_TAG_W]     = tag_q[i];
                    issue_v1[f*XLEN +: XLEN]                    = op1[i];
                    issue_v2[f*XLEN +: XLEN]                    = op2[i];
                    issue_payload[f*PAYLOAD_W +: PAYLOAD_W]     = pay_q[i];
                end
            end
        end
    end

    assign fire = issue_valid & issue_ready & {NUM_FU_TYPES{~squash}};

    always_comb begin
        freed  = '0;
        n_fire = '0;
        for (int f = 0; f < NUM_FU_TYPES; f++) begin
            n_fire = n_fire + CNT_W'(fire[f]);
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (sel[f][i] && fire[f]) begin
                    freed[i] = 1'b1;
                end
            end
        end
    end

    // Allocation looks only at registered busy bits, so an entry freed this
    // cycle is never handed out again in the same cycle.
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
        fu_ok    = ({1'b0, dp_fu_type} < C_NUM_FU);
        alloc_ok = dp_valid & dp_ready & fu_ok & ~squash;
        busy_d   = busy_q & ~freed;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (alloc_ok && (alloc_idx == IDX_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        free_count_d = free_count_q - CNT_W'(alloc_ok) + n_fire;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q       <= '0;
            free_count_q <= C_FULL;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age_q[i] <= '0;
            end
        end else if (squash) begin
            busy_q       <= '0;
            free_count_q <= C_FULL;
        end else begin
            busy_q       <= busy_d;
            free_count_q <= free_count_d;
            if (alloc_ok) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    for (int j = 0; j < NUM_ENTRIES; j++) begin
                        if (alloc_idx == IDX_W'(i)) begin
                            age_q[i][j] <= 1'b0;
                        end else if (alloc_idx == IDX_W'(j)) begin
                            age_q[i][j] <= busy_q[i];
                        end
                    end
                end
            end
        end
    end

    // Payload and operand storage; only meaningful while the entry is busy.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (alloc_ok && (alloc_idx == IDX_W'(i))) begin
                fu_q[i]  <= dp_fu_type;
                tag_q[i] <= dp_rob_tag;
                t1_q[i]  <= dp_t1;
                t2_q[i]  <= dp_t2;
                r1_q[i]  <= dp_r1 | dp_lk1.hit;
                r2_q[i]  <= dp_r2 | dp_lk2.hit;
                v1_q[i]  <= dp_r1 ? dp_v1 : dp_lk1.val;
                v2_q[i]  <= dp_r2 ? dp_v2 : dp_lk2.val;
                pay_q[i] <= dp_payload;
            end else begin
                if (wk1[i]) begin
                    r1_q[i] <= 1'b1;
                    v1_q[i] <= lk1[i].val;
                end
                if (wk2[i]) begin
                    r2_q[i] <= 1'b1;
                    v2_q[i] <= lk2[i].val;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_pool.sv
`default_nettype none
// Testbench for rs_pool: directed scenarios and randomized traffic checked
// against an entry-list reference model with dispatch sequence numbers.
module tb_rs_pool;

    localparam int NE = 8;
    localparam int NF = 4;
    localparam int NC = 2;
    localparam int TW = 5;
    localparam int XW = 32;
    localparam int PW = 64;
`ifdef RS_WAKEUP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              squash;
    logic              dp_valid;
    logic              dp_ready;
    logic [1:0]        dp_fu_type;
    logic [TW-1:0]     dp_rob_tag, dp_t1, dp_t2;
    logic              dp_r1, dp_r2;
    logic [XW-1:0]     dp_v1, dp_v2;
    logic [PW-1:0]     dp_payload;
    logic [NC-1:0]     cdb_valid;
    logic [NC*TW-1:0]  cdb_tag;
    logic [NC*XW-1:0]  cdb_value;
    logic [NF-1:0]     issue_valid;
    logic [NF-1:0]     issue_ready;
    logic [NF*TW-1:0]  issue_rob_tag;
    logic [NF*XW-1:0]  issue_v1, issue_v2;
    logic [NF*PW-1:0]  issue_payload;
    logic [3:0]        free_count;

    rs_pool dut (
        .clock(clock), .reset(reset), .squash(squash),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_fu_type(dp_fu_type),
        .dp_rob_tag(dp_rob_tag), .dp_t1(dp_t1), .dp_t2(dp_t2),
        .dp_r1(dp_r1), .dp_r2(dp_r2), .dp_v1(dp_v1), .dp_v2(dp_v2),
        .dp_payload(dp_payload), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .issue_rob_tag(issue_rob_tag),
        .issue_v1(issue_v1), .issue_v2(issue_v2),
        .issue_payload(issue_payload), .free_count(free_count)
    );

    always #5 clock = ~clock;

    // Reference model: one slot per pool entry, age given by sequence number.
    bit          m_busy [NE];
    bit [1:0]    m_fu   [NE];
    bit [TW-1:0] m_tag  [NE];
    bit [TW-1:0] m_t1   [NE];
    bit [TW-1:0] m_t2   [NE];
    bit          m_r1   [NE];
    bit          m_r2   [NE];
    bit [XW-1:0] m_v1   [NE];
    bit [XW-1:0] m_v2   [NE];
    bit [PW-1:0] m_pay  [NE];
    int          m_seq  [NE];
    int          seq_ctr;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cdb_hit(input bit [TW-1:0] t, output bit [XW-1:0] v);
        v = '0;
        for (int k = 0; k < NC; k++) begin
            if (cdb_valid[k] && cdb_tag[k*TW +: TW] == t) begin
                v = cdb_value[k*XW +: XW];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit src_ready(input bit r, input bit [TW-1:0] t);
        bit [XW-1:0] d;
        return r || (BYPASS && cdb_hit(t, d));
    endfunction

    function automatic bit [XW-1:0] src_value(input bit r, input bit [XW-1:0] v, input bit [TW-1:0] t);
        bit [XW-1:0] d;
        if (!r && BYPASS && cdb_hit(t, d)) return d;
        return v;
    endfunction

    function automatic int exp_sel(input int f);
        int best = -1;
        for (int i = 0; i < NE; i++) begin
            if (m_busy[i] && m_fu[i] == f[1:0] &&
                src_ready(m_r1[i], m_t1[i]) && src_ready(m_r2[i], m_t2[i]) &&
                (best < 0 || m_seq[i] < m_seq[best])) best = i;
        end
        return best;
    endfunction

    function automatic int n_free();
        int n = 0;
        for (int i = 0; i < NE; i++) if (!m_busy[i]) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NE; i++) m_busy[i] = 1'b0;
    endtask

    // Compare outputs for the current inputs, advance the model, clock once.
    task automatic step();
        int e [NF];
        int aidx;
        int nf;
        bit [XW-1:0] d;
        #1;
        nf = n_free();
        check("dp_ready", dp_ready, nf != 0);
        check("free_count", free_count, nf);
        for (int f = 0; f < NF; f++) begin
            e[f] = exp_sel(f);
            check($sformatf("issue_valid[%0d]", f), issue_valid[f], e[f] >= 0);
            if (e[f] >= 0) begin
                check($sformatf("issue_rob_tag[%0d]", f), issue_rob_tag[f*TW +: TW], m_tag[e[f]]);
                check($sformatf("issue_v1[%0d]", f), issue_v1[f*XW +: XW],
                      src_value(m_r1[e[f]], m_v1[e[f]], m_t1[e[f]]));
                check($sformatf("issue_v2[%0d]", f), issue_v2[f*XW +: XW],
                      src_value(m_r2[e[f]], m_v2[e[f]], m_t2[e[f]]));
                check($sformatf("issue_payload[%0d]", f), issue_payload[f*PW +: PW], m_pay[e[f]]);
            end
        end
        if (squash) begin
            model_clear();
        end else begin
            aidx = -1;
            if (dp_valid && nf > 0 && dp_fu_type < NF) begin
                for (int i = NE - 1; i >= 0; i--) if (!m_busy[i]) aidx = i;
            end
            for (int i = 0; i < NE; i++) begin
                if (m_busy[i] && !m_r1[i] && cdb_hit(m_t1[i], d)) begin m_r1[i] = 1'b1; m_v1[i] = d; end
                if (m_busy[i] && !m_r2[i] && cdb_hit(m_t2[i], d)) begin m_r2[i] = 1'b1; m_v2[i] = d; end
            end
            for (int f = 0; f < NF; f++) if (e[f] >= 0 && issue_ready[f]) m_busy[e[f]] = 1'b0;
            if (aidx >= 0) begin
                m_busy[aidx] = 1'b1;
                m_fu[aidx]   = dp_fu_type;
                m_tag[aidx]  = dp_rob_tag;
                m_t1[aidx]   = dp_t1;
                m_t2[aidx]   = dp_t2;
                m_pay[aidx]  = dp_payload;
                m_seq[aidx]  = seq_ctr++;
                m_r1[aidx]   = dp_r1 || cdb_hit(dp_t1, d);
                m_v1[aidx]   = dp_r1 ? dp_v1 : d;
                m_r2[aidx]   = dp_r2 || cdb_hit(dp_t2, d);
                m_v2[aidx]   = dp_r2 ? dp_v2 : d;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        squash = 0; dp_valid = 0; dp_fu_type = 0; dp_rob_tag = 0;
        dp_t1 = 0; dp_t2 = 0; dp_r1 = 1; dp_r2 = 1; dp_v1 = 0; dp_v2 = 0;
        dp_payload = 0; cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
    endtask

    task automatic disp(input bit [1:0] fu, input bit [TW-1:0] tag,
                        input bit [TW-1:0] t1, input bit r1,
                        input bit [TW-1:0] t2, input bit r2);
        dp_valid = 1; dp_fu_type = fu; dp_rob_tag = tag;
        dp_t1 = t1; dp_r1 = r1; dp_v1 = $urandom;
        dp_t2 = t2; dp_r2 = r2; dp_v2 = $urandom;
        dp_payload = {$urandom, $urandom};
    endtask

    task automatic cdb(input int ch, input bit [TW-1:0] t, input bit [XW-1:0] v);
        cdb_valid[ch] = 1'b1;
        cdb_tag[ch*TW +: TW] = t;
        cdb_value[ch*XW +: XW] = v;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; seq_ctr = 0;
        model_clear();
        idle();
        issue_ready = '0;
        reset = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        step();

        // Fill with eight ready ALU ops under backpressure, then a ninth request
        for (int i = 0; i < 9; i++) begin
            disp(2'd0, TW'(i + 1), 0, 1, 0, 1);
            step();
        end
        idle();
        step();
        check("fill_full_ready", dp_ready, 1'b0);
        check("fill_oldest_tag", issue_rob_tag[TW-1:0], 5'd1);
        // Drain three, leaving five busy, then squash
        issue_ready = 4'b0001;
        repeat (3) step();
        issue_ready = '0;
        squash = 1;
        step();
        squash = 0;
        check("squash_free", free_count, 4'd8);
        check("squash_valid", issue_valid, 4'd0);
        step();

        // Wakeup through CDB channel 1
        disp(2'd0, 5'd3, 5'd7, 0, 0, 1);
        step();
        idle();
        step();
        cdb(1, 5'd7, 32'hDEADBEEF);
        step();
        idle();
        check("wakeup_v1", issue_v1[XW-1:0], 32'hDEADBEEF);
        issue_ready = 4'b0001;
        step();
        issue_ready = '0;

        // Dispatch-cycle capture
        disp(2'd0, 5'd10, 0, 1, 5'd9, 0);
        cdb(0, 5'd9, 32'h55);
        step();
        idle();
        check("capture_v2", issue_v2[XW-1:0], 32'h55);
        issue_ready = 4'b0001;
        step();
        issue_ready = '0;

        // Age order with the oldest entry waiting on tag 12
        disp(2'd0, 5'd4, 5'd12, 0, 0, 1); step();
        disp(2'd0, 5'd5, 0, 1, 0, 1);     step();
        disp(2'd0, 5'd6, 0, 1, 0, 1);     step();
        idle();
        issue_ready = 4'b0001;
        repeat (3) step();
        cdb(0, 5'd12, 32'h1234);
        step();
        idle();
        repeat (2) step();
        issue_ready = '0;

        // Parallel ports with LOAD held off
        disp(2'd1, 5'd20, 0, 1, 0, 1); step();
        disp(2'd3, 5'd21, 0, 1, 0, 1); step();
        idle();
        issue_ready = 4'b1000;
        repeat (3) step();
        issue_ready = 4'b0010;
        step();
        issue_ready = '0;

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            idle();
            if ($urandom_range(0, 3) != 0)
                disp(2'($urandom), 5'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                     5'($urandom_range(0, 7)), 1'($urandom));
            for (int k = 0; k < NC; k++)
                if ($urandom_range(0, 2) == 0) cdb(k, 5'($urandom_range(0, 7)), $urandom);
            issue_ready = 4'($urandom);
            squash = ($urandom_range(0, 99) == 0);
            step();
        end

        // Asynchronous reset mid-cycle with entries in flight
        idle();
        issue_ready = '0;
        for (int i = 0; i < 4; i++) begin
            disp(2'($urandom), 5'($urandom), 0, 1, 0, 1);
            step();
        end
        idle();
        #2 reset = 1;
        #1;
        check("async_rst_ready", dp_ready, 1'b1);
        check("async_rst_free", free_count, 4'd8);
        check("async_rst_valid", issue_valid, 4'd0);
        model_clear();
        @(negedge clock);
        reset = 0;
        @(posedge clock);
        #1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
